// File: rtl/id_ex_operand_forward_stage_if.sv
// ID/EX bundle: decoded ID instruction, hazard-unit forward enables, EX outputs.
// FWD_STATS_EN adds the fwd_count / stall_count statistics outputs.
interface id_ex_operand_forward_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16
);
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [ADDR_WIDTH-1:0] id_rs1_addr;
    logic [ADDR_WIDTH-1:0] id_rs2_addr;
    logic [ADDR_WIDTH-1:0] id_rd_addr;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [CTRL_WIDTH-1:0] id_ctrl;
    logic                  id_mem_read;
    logic                  fwd_rs1_mem;
    logic                  fwd_rs2_mem;
    logic                  fwd_rs1_wb;
    logic                  fwd_rs2_wb;
    logic                  mem_reg_write;
    logic                  wb_reg_write;
    logic [DATA_WIDTH-1:0] mem_alu_result;
    logic [DATA_WIDTH-1:0] wb_write_data;
    logic                  mem_busy;
    logic                  flush;
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [ADDR_WIDTH-1:0] ex_rd_addr;
    logic [CTRL_WIDTH-1:0] ex_ctrl;
    logic                  ex_mem_read;
    logic [DATA_WIDTH-1:0] ex_op1;
    logic [DATA_WIDTH-1:0] ex_op2;
    logic                  stall_if_id;
`ifdef FWD_STATS_EN
    logic [31:0]           fwd_count;
    logic [31:0]           stall_count;
`endif

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_rs1_data, id_rs2_data, id_ctrl, id_mem_read,
        output fwd_rs1_mem, fwd_rs2_mem, fwd_rs1_wb, fwd_rs2_wb,
        output mem_reg_write, wb_reg_write, mem_alu_result, wb_write_data,
        output mem_busy, flush,
        input  ex_valid, ex_pc, ex_rd_addr, ex_ctrl, ex_mem_read,
        input  ex_op1, ex_op2, stall_if_id
`ifdef FWD_STATS_EN
        , input fwd_count, stall_count
`endif
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  id_rs1_data, id_rs2_data, id_ctrl, id_mem_read,
        input  fwd_rs1_mem, fwd_rs2_mem, fwd_rs1_wb, fwd_rs2_wb,
        input  mem_reg_write, wb_reg_write, mem_alu_result, wb_write_data,
        input  mem_busy, flush,
        output ex_valid, ex_pc, ex_rd_addr, ex_ctrl, ex_mem_read,
        output ex_op1, ex_op2, stall_if_id
`ifdef FWD_STATS_EN
        , output fwd_count, stall_count
`endif
    );
endinterface

// File: rtl/id_ex_operand_forward_stage.sv
// ID/EX register with EX operand forwarding, load-use interlock and busy freeze.
// FWD_STATS_EN adds forwarding / stall event counters.
module id_ex_operand_forward_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    id_ex_operand_forward_stage_if.slave bus
);
    typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_HOLD} state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] d1;
        logic [DATA_WIDTH-1:0] d2;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  mem_read;
    } id_ex_t;

    state_t state_q, state_d;
    id_ex_t ex_q, ex_d, id_word;
    logic   pend_q, pend_d;
    logic   lu_hit, stall;
    logic   rs1_mem, rs1_wb, rs2_mem, rs2_wb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        id_word.valid    = bus.id_valid;
        id_word.pc       = bus.id_pc;
        id_word.rd       = bus.id_rd_addr;
        id_word.rs1      = bus.id_rs1_addr;
        id_word.rs2      = bus.id_rs2_addr;
        id_word.d1       = bus.id_rs1_data;
        id_word.d2       = bus.id_rs2_data;
        id_word.ctrl     = bus.id_valid ? bus.id_ctrl : '0;
        id_word.mem_read = bus.id_valid & bus.id_mem_read;
    end

    assign lu_hit = bus.id_valid & ex_q.valid & ex_q.mem_read
                  & (ex_q.rd != '0)
                  & ((ex_q.rd == bus.id_rs1_addr)
                   | (ex_q.rd == bus.id_rs2_addr));

    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        pend_d  = pend_q;
        stall   = (state_q == MEM_HOLD) | bus.mem_busy
                | ((state_q == RUN) & lu_hit & ~bus.flush);
        if (bus.mem_busy) begin
            // A flush seen while frozen must survive until EX can move.
            state_d = MEM_HOLD;
            pend_d  = pend_q | bus.flush;
        end else begin
            pend_d = 1'b0;
            if (bus.flush | pend_q) begin
                ex_d    = '0;
                state_d = RUN;
            end else if (lu_hit) begin
                ex_d    = '0;
                state_d = LU_BUBBLE;
            end else begin
                ex_d    = id_word;
                state_d = RUN;
            end
        end
    end

    // x0 never forwards and only writing producers are eligible.
    assign rs1_mem = bus.fwd_rs1_mem & bus.mem_reg_write & (ex_q.rs1 != '0);
    assign rs1_wb  = bus.fwd_rs1_wb  & bus.wb_reg_write  & (ex_q.rs1 != '0);
    assign rs2_mem = bus.fwd_rs2_mem & bus.mem_reg_write & (ex_q.rs2 != '0);
    assign rs2_wb  = bus.fwd_rs2_wb  & bus.wb_reg_write  & (ex_q.rs2 != '0);

    assign bus.ex_op1 = rs1_mem ? bus.mem_alu_result :
                        rs1_wb  ? bus.wb_write_data  : ex_q.d1;
    assign bus.ex_op2 = rs2_mem ? bus.mem_alu_result :
                        rs2_wb  ? bus.wb_write_data  : ex_q.d2;

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rd_addr  = ex_q.rd;
    assign bus.ex_ctrl     = ex_q.ctrl;
    assign bus.ex_mem_read = ex_q.mem_read;
    assign bus.stall_if_id = stall;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (ex_q.valid & (rs1_mem | rs1_wb | rs2_mem | rs2_wb))
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            if (stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.fwd_count   = fwd_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`endif
endmodule
